// File: rtl/mult_pkg.sv
// Shared constants and state encoding for the sequential multiplier.
package mult_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mult_addsub.sv
// Combinational (WIDTH+1)-bit adder/subtractor used for one partial-product step.
module mult_addsub #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0] a_i,
  input  logic [WIDTH:0] b_i,
  input  logic           sub_i,
  output logic [WIDTH:0] y_o
);

  always_comb begin
    y_o = sub_i ? (a_i - b_i) : (a_i + b_i);
  end

endmodule

// File: rtl/booth_multiply.sv
// Sequential WIDTH x WIDTH multiplier, one partial product per enabled cycle,
// signed (last partial product subtracted) or unsigned.
//
//   state | meaning
//   IDLE  | waiting for start
//   BUSY  | stepping through WIDTH partial products
//   DONE  | product valid on Hi/Lo for one cycle
module booth_multiply
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   mcand_q, mcand_d;
  logic             signed_q, signed_d;
  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0] mplr_q, mplr_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic             last_step;
  logic [WIDTH:0]   pp;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   acc_nxt;
  logic [WIDTH-1:0] mplr_nxt;

  assign last_step = (cnt_q == CW'(WIDTH - 1));
  assign pp        = mplr_q[0] ? mcand_q : '0;

  mult_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a_i   (acc_q),
    .b_i   (pp),
    .sub_i (signed_q & last_step),
    .y_o   (sum)
  );

  // Shift the (acc, multiplier) pair right by one; the carry/sign becomes the new MSB.
  assign acc_nxt  = {(signed_q & sum[WIDTH]), sum[WIDTH:1]};
  assign mplr_nxt = {sum[0], mplr_q[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      signed_q <= 1'b0;
      acc_q    <= '0;
      mplr_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      signed_q <= signed_d;
      acc_q    <= acc_d;
      mplr_q   <= mplr_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    signed_d = signed_q;
    acc_d    = acc_q;
    mplr_d   = mplr_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    if (enable) begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            mcand_d  = {(is_signed & A[WIDTH-1]), A};
            signed_d = is_signed;
            acc_d    = '0;
            mplr_d   = B;
            cnt_d    = '0;
            state_d  = BUSY;
          end else begin
            state_d  = IDLE;
          end
        end
        BUSY: begin
          acc_d  = acc_nxt;
          mplr_d = mplr_nxt;
          cnt_d  = cnt_q + 1'b1;
          if (last_step) begin
            hi_d    = acc_nxt[WIDTH-1:0];
            lo_d    = mplr_nxt;
            state_d = DONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign busy = (state_q == BUSY);
  assign done = (state_q == DONE);
  assign Hi   = hi_q;
  assign Lo   = lo_q;

endmodule

// File: tb/tb_booth_multiply.sv
// Scoreboard bench: expected products queued at issue, popped by monitors on done.
module tb_booth_multiply;

  logic        clk = 1'b0;
  logic        rst, en, st, sg;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] hi, lo;

  logic        st8, sg8;
  logic [7:0]  a8, b8;
  logic        busy8, done8;
  logic [7:0]  hi8, lo8;

  int n_cmp = 0;
  int n_err = 0;

  logic [63:0] q32[$];
  logic [15:0] q8[$];
  logic [63:0] last_prod;
  logic        done_seen  = 1'b0;
  logic        done8_seen = 1'b0;

  always #5 clk = ~clk;

  booth_multiply #(.WIDTH(32)) dut (
    .clk(clk), .reset(rst), .enable(en), .start(st), .is_signed(sg),
    .A(a), .B(b), .busy(busy), .done(done), .Hi(hi), .Lo(lo)
  );

  booth_multiply #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(rst), .enable(1'b1), .start(st8), .is_signed(sg8),
    .A(a8), .B(b8), .busy(busy8), .done(done8), .Hi(hi8), .Lo(lo8)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done && !done_seen) begin
      if (q32.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_done32: got done=1, expected no pending result");
      end else begin
        check("product32", {hi, lo}, q32.pop_front());
      end
    end
    done_seen = done;
  end

  always @(negedge clk) begin
    if (done8 && !done8_seen) begin
      if (q8.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_done8: got done=1, expected no pending result");
      end else begin
        check("product8", {48'd0, hi8, lo8}, {48'd0, q8.pop_front()});
      end
    end
    done8_seen = done8;
  end

  // Called at #1 after a posedge; returns #1 after the accepting edge.
  task automatic start_op(input logic [31:0] av, input logic [31:0] bv, input logic s,
                          input logic [63:0] e);
    a = av; b = bv; sg = s; st = 1'b1;
    q32.push_back(e);
    @(posedge clk); #1;
    st = 1'b0; a = ~av; b = ~bv; sg = ~s;
    check("busy_after_accept", {63'd0, busy}, 64'd1);
  endtask

  task automatic wait_done(input int exp_lat, input int stall_at, input int stall_len,
                           input int junk_at, input logic [63:0] e);
    int  cyc = 0;
    bit  got = 0;
    for (int i = 0; i < 200; i++) begin
      if (cyc == stall_at) en = 1'b0;
      if (cyc == stall_at + stall_len) en = 1'b1;
      if (cyc == junk_at) begin st = 1'b1; a = 32'd5; b = 32'd5; sg = 1'b0; end
      if (cyc == junk_at + 2) st = 1'b0;
      @(posedge clk); #1;
      cyc++;
      if (done) begin got = 1; break; end
      check("busy_during_op", {63'd0, busy}, 64'd1);
      check("hilo_hold_busy", {hi, lo}, last_prod);
    end
    en = 1'b1; st = 1'b0;
    check("latency", got ? 64'(cyc) : 64'hFFFF_FFFF_FFFF_FFFF, 64'(exp_lat));
    check("busy_in_done", {63'd0, busy}, 64'd0);
    last_prod = e;
  endtask

  task automatic run(input logic [31:0] av, input logic [31:0] bv, input logic s,
                     input logic [63:0] e);
    start_op(av, bv, s, e);
    wait_done(32, -1, 0, -1, e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1);
  end

  initial begin
    bit stray;
    int cyc8;
    rst = 1'b1; en = 1'b1; st = 1'b0; sg = 1'b0; a = '0; b = '0;
    st8 = 1'b0; sg8 = 1'b0; a8 = '0; b8 = '0;
    last_prod = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs32", {60'd0, busy, done, |hi, |lo}, 64'd0);
    check("reset_outputs8", {60'd0, busy8, done8, |hi8, |lo8}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run(32'hFFFF_FFCE, 32'hFFFF_FFFB, 1'b1, 64'h00000000_000000FA);
    run(32'hFFFF_FFFF, 32'h0000_0005, 1'b1, 64'hFFFFFFFF_FFFFFFFB);
    run(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h40000000_00000000);
    run(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFFFFFE_00000001);
    run(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h00000000_00000001);
    run(32'h1234_5678, 32'h0000_0010, 1'b0, 64'h00000001_23456780);
    run(32'h0000_0000, 32'h1234_5678, 1'b0, 64'h00000000_00000000);
    run(32'h0000_0007, 32'hFFFF_FFFD, 1'b1, 64'hFFFFFFFF_FFFFFFEB);

    // Restart attempts during BUSY plus a 3-cycle stall: original product, 35 cycles
    start_op(32'd1000, 32'hFFFF_FFFE, 1'b1, 64'hFFFFFFFF_FFFFF830);
    wait_done(35, 5, 3, 12, 64'hFFFFFFFF_FFFFF830);

    // done held by enable=0, then back to IDLE
    run(32'd3, 32'd7, 1'b0, 64'h00000000_00000015);
    en = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      check("done_held", {63'd0, done}, 64'd1);
      check("hilo_held", {hi, lo}, 64'h00000000_00000015);
    end
    en = 1'b1;
    @(posedge clk); #1;
    check("done_to_idle", {62'd0, busy, done}, 64'd0);

    // Reset at cycle 10 of BUSY, with a coincident start
    start_op(32'h0000_1234, 32'h0000_5678, 1'b0, 64'h0);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1; st = 1'b1; a = 32'd9; b = 32'd9; sg = 1'b0;
    @(posedge clk); #1;
    check("abort_outputs", {60'd0, busy, done, |hi, |lo}, 64'd0);
    rst = 1'b0; st = 1'b0;
    q32.delete();
    last_prod = '0;
    stray = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) stray = 1;
    end
    check("no_done_after_abort", {63'd0, stray}, 64'd0);

    // Back-to-back: second start accepted in the DONE cycle
    run(32'h0001_0000, 32'h0001_0000, 1'b0, 64'h00000001_00000000);
    start_op(32'd100, 32'd100, 1'b1, 64'h00000000_00002710);
    wait_done(32, -1, 0, -1, 64'h00000000_00002710);

    // WIDTH=8 instance
    a8 = 8'h7F; b8 = 8'h80; sg8 = 1'b1; st8 = 1'b1;
    q8.push_back(16'hC080);
    @(posedge clk); #1;
    st8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
    cyc8 = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      cyc8++;
      if (done8) break;
    end
    check("latency8", done8 ? 64'(cyc8) : 64'hFFFF_FFFF_FFFF_FFFF, 64'd8);

    repeat (3) @(posedge clk);
    #1;
    check("queues_drained", 64'(q32.size() + q8.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/booth_multiply.md
BOOTH_MULTIPLY -- requirements
Module: booth_multiply

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits (legal 4..64, even).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port enable  input  1  stall control; 0 freezes all state.
REQ-005 SHALL have port start  input  1  request a new multiply.
REQ-006 SHALL have port is_signed  input  1  1 = two's-complement (MULT), 0 = unsigned (MULTU).
REQ-007 SHALL have port A  input  WIDTH  multiplicand.
REQ-008 SHALL have port B  input  WIDTH  multiplier.
REQ-009 SHALL have port busy  output  1  operation in progress.
REQ-010 SHALL have port done  output  1  one-cycle result-valid pulse.
REQ-011 SHALL have port Hi  output  WIDTH  upper half of the product.
REQ-012 SHALL have port Lo  output  WIDTH  lower half of the product.

Function
REQ-013 SHALL implement states IDLE, BUSY, DONE; every transition requires enable=1 at the clock edge.
REQ-014 SHALL accept start in IDLE or DONE with enable=1: capture A, B and is_signed, clear the iteration counter, go to BUSY.
REQ-015 SHALL ignore start, A, B and is_signed while in BUSY; captured operands alone determine the result.
REQ-016 SHALL perform one partial-product step per enabled cycle in BUSY, exactly WIDTH steps.
REQ-017 SHALL, on the edge that completes step WIDTH, load {Hi,Lo} with the full 2*WIDTH-bit product and enter DONE.
REQ-018 SHALL yield a latency of exactly WIDTH enabled cycles from the accepting edge to done=1; each enable=0 cycle adds one.
REQ-019 SHALL treat operands as signed when is_signed=1 (final partial product subtracted) and as zero-extended when is_signed=0.
REQ-020 SHALL assert busy only in BUSY and done only in DONE; DONE lasts one cycle and returns to IDLE unless start is accepted.
REQ-021 SHALL hold Hi/Lo stable from the DONE load until the next product load; they do not change during BUSY.
REQ-022 SHALL, when enable=0, hold state, counter, busy, done, Hi and Lo unchanged, including a held done=1.
REQ-023 SHALL treat start with operand 0, most-negative values, or all-ones identically; no early termination.

Reset
REQ-024 SHALL, on any clock edge with reset=1, regardless of enable or state, enter IDLE, clear the counter and internal registers, and drive busy=0, done=0, Hi=0, Lo=0.
REQ-025 SHALL abort an in-progress multiply on reset with no done pulse; start coincident with reset is ignored.

Structure
REQ-026 SHALL place the state encodings (IDLE, BUSY, DONE) and the default WIDTH constant in shared package mult_pkg.
REQ-027 SHALL use one sub-module, mult_addsub: a combinational WIDTH+1-bit adder/subtractor selected by an add/sub input.
REQ-028 SHALL size the iteration counter as clog2(WIDTH)+1 bits; no other sub-modules.

Verification (WIDTH=32 unless stated)
REQ-029 SHALL test signed A=-50, B=-5 -> Hi=0x00000000, Lo=0x000000FA, done exactly 32 cycles after the accepting edge, busy high for those 32 cycles.
REQ-030 SHALL test signed A=-1, B=5 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFFB; then signed A=B=0x80000000 -> Hi=0x40000000, Lo=0x00000000.
REQ-031 SHALL test A=B=0xFFFFFFFF: unsigned -> Hi=0xFFFFFFFE, Lo=0x00000001; signed -> Hi=0x00000000, Lo=0x00000001.
REQ-032 SHALL test start re-asserted with new operands during BUSY plus enable=0 for 3 cycles mid-operation -> original product returned, done at cycle 35.
REQ-033 SHALL test reset=1 at cycle 10 of BUSY -> next edge busy=0, done=0, Hi=Lo=0, no done pulse; start accepted in the DONE cycle -> back-to-back result after 32 more cycles.
REQ-034 SHALL test WIDTH=8 signed A=0x7F, B=0x80 -> Hi=0xC0, Lo=0x80, done 8 cycles after start.
